adaptive_filter: RTL and testbench

// - Streaming first-order filter with run-time mode select, for the sample-rate datapath.
// - ctrl=0: differentiator, y[n] = x[n] - x[n-1].
// - ctrl=1: integrator, y[n] = y[n-1] + x[n].
// - Samples are two's-complement fixed point. Input and output use the same Q format.
//   No scaling is applied, so the fractional point passes through unchanged.

---
 rtl/adaptive_filter.sv | 106 ++++++++++
 tb/tb_adaptive_filter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/adaptive_filter.sv
// -----------------------------------------------------------------------------
// adaptive_filter
// Streaming first-order filter for the sample-rate datapath. Each accepted
// sample is either differentiated (ctrl=0) or integrated (ctrl=1). Both modes
// compute at WORDLENGTH+1 bits, then clamp or wrap the result back to
// WORDLENGTH bits. Input and output use the same Q format, so the fractional
// point passes through unchanged.
//
// Ports
//   clk       in   1           clock, rising edge
//   arst_n    in   1           asynchronous active-low reset
//   ctrl      in   1           mode: 0 = differentiator, 1 = integrator
//   s_tdata   in   WORDLENGTH  input sample, signed
//   s_tvalid  in   1           input sample valid (no backpressure)
//   m_tdata   out  WORDLENGTH  filtered sample, signed, registered
//   m_tvalid  out  1           output valid, registered
// -----------------------------------------------------------------------------
module adaptive_filter #(
    parameter int WORDLENGTH        = 14,
    parameter int FRACTIONAL_LENGTH = 6,
    parameter bit SATURATE          = 1'b1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  ctrl,
    input  logic [WORDLENGTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic [WORDLENGTH-1:0] m_tdata,
    output logic                  m_tvalid
);

    localparam int W = WORDLENGTH;

    // The fractional length only describes the format. Reject a format that
    // has no room for a sign bit.
    generate
        if (FRACTIONAL_LENGTH >= WORDLENGTH || FRACTIONAL_LENGTH < 0) begin : g_bad_format
            $error("adaptive_filter: FRACTIONAL_LENGTH must be in [0, WORDLENGTH-1]");
        end
    endgenerate

    logic [W-1:0] r_x_prev;
    logic [W-1:0] r_acc;
    logic         r_ctrl_prev;
    logic [W-1:0] r_m_tdata;
    logic         r_m_tvalid;

    logic [W:0]   w_x_ext;
    logic [W:0]   w_prev_ext;
    logic [W:0]   w_acc_ext;
    logic [W:0]   w_wide;
    logic [W-1:0] w_result;

    // Sign-extend to W+1 bits. These sums cannot overflow at that width.
    assign w_x_ext    = {s_tdata[W-1], s_tdata};
    assign w_prev_ext = {r_x_prev[W-1], r_x_prev};

    // A mode change restarts the integrator from zero for that sample.
    // The differentiator always uses the real previous input.
    assign w_acc_ext  = (ctrl != r_ctrl_prev) ? '0 : {r_acc[W-1], r_acc};

    assign w_wide = ctrl ? (w_acc_ext + w_x_ext) : (w_x_ext - w_prev_ext);

    generate
        if (SATURATE) begin : g_sat
            // The two top bits disagree only when the W+1-bit result lies
            // outside the W-bit signed range. The top bit then gives the
            // direction of the overflow.
            always_comb begin
                w_result = w_wide[W-1:0];
                if (w_wide[W] != w_wide[W-1]) begin
                    w_result = w_wide[W] ? {1'b1, {(W-1){1'b0}}}
                                         : {1'b0, {(W-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            assign w_result = w_wide[W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_x_prev    <= '0;
            r_acc       <= '0;
            r_ctrl_prev <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tvalid  <= 1'b0;
        end else begin
            r_m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                r_x_prev    <= s_tdata;
                r_ctrl_prev <= ctrl;
                r_m_tdata   <= w_result;
                // The accumulator keeps the clamped value, so it always
                // matches what was put on the output.
                if (ctrl) begin
                    r_acc <= w_result;
                end
            end
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tvalid = r_m_tvalid;

endmodule

// File: tb/tb_adaptive_filter.sv
// -----------------------------------------------------------------------------
// tb_adaptive_filter
// Directed vectors with hand-computed expected values for adaptive_filter
// (WORDLENGTH=14, SATURATE=1).
// -----------------------------------------------------------------------------
module tb_adaptive_filter;

    logic        clk;
    logic        arst_n;
    logic        ctrl;
    logic [13:0] s_tdata;
    logic        s_tvalid;
    logic [13:0] m_tdata;
    logic        m_tvalid;

    int n_compared;
    int n_mismatched;

    adaptive_filter #(
        .WORDLENGTH        (14),
        .FRACTIONAL_LENGTH (6),
        .SATURATE          (1'b1)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .ctrl     (ctrl),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] to14(input int v);
        logic [31:0] t;
        t = v;
        return t[13:0];
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%04h", tag, obs);
        end
    endtask

    // Apply one valid sample, then check the output one cycle later.
    task automatic send(input string tag, input logic c, input int x, input int y);
        ctrl     = c;
        s_tdata  = to14(x);
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        check_val({tag, ".valid"}, {15'd0, m_tvalid}, 16'd1);
        check_val({tag, ".data"},  {2'd0, m_tdata}, {2'd0, to14(y)});
    endtask

    // Idle cycles. The output must be invalid and keep its last value.
    task automatic gap(input string tag, input int n, input int hold);
        s_tvalid = 1'b0;
        s_tdata  = to14(999);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_val({tag, ".valid"}, {15'd0, m_tvalid}, 16'd0);
            check_val({tag, ".hold"},  {2'd0, m_tdata}, {2'd0, to14(hold)});
        end
    endtask

    task automatic do_reset(input string tag);
        s_tvalid = 1'b0;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check_val({tag, ".rst_valid"}, {15'd0, m_tvalid}, 16'd0);
        check_val({tag, ".rst_data"},  {2'd0, m_tdata}, 16'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        arst_n   = 1'b1;
        ctrl     = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        #2;

        // Differentiator.
        do_reset("diff");
        send("diff0", 1'b0, 64, 64);
        send("diff1", 1'b0, 128, 64);
        send("diff2", 1'b0, 128, 0);
        send("diff3", 1'b0, 0, -128);
        check_val("diff3.hex", {2'd0, m_tdata}, 16'h3F80);

        // Integrator.
        do_reset("int");
        send("int0", 1'b1, 64, 64);
        send("int1", 1'b1, 64, 128);
        send("int2", 1'b1, -32, 96);
        send("int3", 1'b1, -96, 0);

        // Saturation, integrator and differentiator.
        do_reset("sati");
        send("sati0", 1'b1, 8000, 8000);
        send("sati1", 1'b1, 8000, 8191);
        do_reset("satd");
        send("satd0", 1'b0, 8191, 8191);
        send("satd1", 1'b0, -8192, -8192);

        // Gaps between valid samples.
        do_reset("gap");
        send("gap0", 1'b0, 10, 10);
        gap("gapidle", 3, 10);
        send("gap1", 1'b0, 30, 20);

        // Mode switching. The ctrl toggle during the idle cycle does nothing.
        do_reset("mode");
        send("mode0", 1'b1, 5, 5);
        send("mode1", 1'b1, 5, 10);
        send("mode2", 1'b0, 7, 2);
        ctrl = 1'b1;
        gap("modeidle", 1, 2);
        send("mode3", 1'b1, 3, 3);

        // Reset mid-stream.
        do_reset("mid");
        send("mid0", 1'b1, 50, 50);
        send("mid1", 1'b1, 50, 100);
        do_reset("midrst");
        send("mid2", 1'b1, 4, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
